rle_playback_ctrl: RTL
======================

# rle_playback_ctrl

Run-length playback sequencer between the QSPI flash reader and the VGA pixel output. It throttles the flash reader with `shift_data`, buffers 18-bit instruction words in a small FIFO, and expands each word into a run of identical pixels during active display. It starts playback on a frame boundary and flags underrun and overflow.

## Interface
- `FIFO_DEPTH`, 4: instruction FIFO entries; power of two, ≥ 4.
- `SHIFT_MARGIN`, 2: minimum free entries required to keep `shift_data` high; covers one word in flight.

- `clk`  in  1  system/pixel clock; one pixel per cycle.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  18  instruction word from the flash reader: [17:6] `run_len`, [5:0] `color` (RGB222).
- `instr_valid`  in  1  word-available strobe from the flash reader.
- `shift_data`  out  1  request to the flash reader to keep streaming words.
- `frame_start`  in  1  one-cycle pulse at the start of a frame, from the VGA timing block.
- `display_on`  in  1  current cycle is an active pixel.
- `rgb`  out  6  registered pixel colour.
- `playing`  out  1  the sequencer is in PLAY.
- `underrun`  out  1  sticky flag: a pixel was needed while no data was available.
- `overflow`  out  1  sticky flag: a word arrived while the FIFO was full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

## Operation
- **Word capture**
  - A word is captured on each rising edge of `instr_valid`, i.e. `instr_valid`=1 and its registered copy `instr_valid_q`=0.
  - While `instr_valid` stays high, no further words are captured.
- **Fetch throttle**
  - `shift_data` is registered.
  - It is high when (FIFO_DEPTH − fifo_level) ≥ SHIFT_MARGIN, otherwise low.
- **FIFO**
  - Circular buffer with read and write pointers; wrap-around at FIFO_DEPTH.
  - Push and pop in the same cycle: both take effect and the level is unchanged. This holds even when the FIFO is full, because the pop frees an entry first.
  - Push while full with no pop: the word is dropped, `overflow` is set, and the FIFO is unchanged.
- **Run register**
  - Holds `cur_color[5:0]` and `remain[12:0]` (pixels left in the current run; 0 means empty).
  - Word length is `run_len`+1, giving runs of 1..4096 pixels.
- **State machine**
  - **SYNC** (reset state): `rgb`=0 and no pops. Moves to PLAY on `frame_start`=1 with fifo_level ≥ 1; otherwise stays in SYNC.
  - **PLAY**: there is no exit other than reset. Later `frame_start` pulses are ignored and the stream is continuous.
- **PLAY, cycle with `display_on`=1**
  - `remain` > 1: `rgb`←`cur_color`, `remain`−1.
  - `remain` = 1: `rgb`←`cur_color`. If the FIFO is non-empty, pop and load the head with `remain`←`run_len`+1; otherwise `remain`←0.
  - `remain` = 0 and FIFO non-empty: `rgb`←head colour, `remain`←`run_len` (the current pixel counts toward the run), pop.
  - `remain` = 0 and FIFO empty: `rgb`←0, `underrun`←1.
- **PLAY, cycle with `display_on`=0**
  - `rgb`←0.
  - If `remain`=0 and the FIFO is non-empty, preload: pop with `remain`←`run_len`+1.
  - Otherwise hold.
- **Sticky flags**: `underrun` and `overflow` are cleared only by reset.

## Timing
- Reset (asynchronous, immediate) values:
  - `rgb`=0, `shift_data`=0, `playing`=0, `underrun`=0, `overflow`=0, `fifo_level`=0.
  - State SYNC, pointers 0, `remain`=0, `instr_valid_q`=0.
- `shift_data` rises the first clock after reset is released.
- Capture latency: a word captured at edge N is in the FIFO (`fifo_level` updated) after edge N. It can be popped at edge N+1.
- `rgb` latency: `rgb` at the output after edge N corresponds to `display_on` sampled at edge N, i.e. one cycle of latency. The VGA timing block delays hsync/vsync by one cycle to match.
- `playing` rises the cycle after the qualifying `frame_start`.
- Reset asserted mid-run aborts immediately. After release, the block returns to SYNC and waits for the next `frame_start`.

## Test plan
- **Reset**: assert `rst_n`=0 mid-PLAY → all outputs 0 at once. After release, `shift_data`=1 the next cycle, `playing`=0, and the block waits for `frame_start`.
- **Basic run**
  - Stimulus: push {12'd2, 6'h30} and {12'd0, 6'h0C}, pulse `frame_start`, then hold `display_on`=1.
  - Required: `rgb` = 30,30,30,0C, then 00 with `underrun`=1.
- **Throttle**: DEPTH=4, MARGIN=2, no display → after 3 pushes `shift_data`=0. One pop with `display_on` restores it to 1.
- **Blanking preload**
  - Stimulus: `remain` reaches 0 during `display_on`=0.
  - Required: the head is popped during blanking, and the first active pixel shows its colour with no lost pixel; the run totals exactly `run_len`+1 pixels.
- **Overflow**
  - Stimulus: force 5 `instr_valid` rising edges with no pops.
  - Required: `fifo_level`=4, `overflow`=1, and the 5th word is discarded (the FIFO contents equal words 1–4).
- **Wrap and simultaneous push/pop**
  - Stimulus: stream 20 single-pixel words while `display_on`=1 continuously.
  - Required: output colours appear in input order across pointer wrap, and `fifo_level` stays steady on cycles with a simultaneous push and pop.

Source files
------------

// File: rtl/rle_playback_ctrl.sv
// rle_playback_ctrl: buffers run-length words from the flash reader and expands them into pixel runs during active display
module rle_playback_ctrl #(
    parameter int FIFO_DEPTH   = 4,
    parameter int SHIFT_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [17:0]                   instr,
    input  logic                          instr_valid,
    output logic                          shift_data,
    input  logic                          frame_start,
    input  logic                          display_on,
    output logic [5:0]                    rgb,
    output logic                          playing,
    output logic                          underrun,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic {SYNC, PLAY} state_t;
    state_t        state_q, state_d;
    logic [17:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [12:0]   remain_q, remain_d, head_len;
    logic [5:0]    cur_color_q, cur_color_d, rgb_q, rgb_d, head_color;
    logic          shift_q, shift_d, underrun_q, underrun_d, overflow_q, overflow_d, valid_q;
    logic          play, empty, full, push_req, push, pop;
    always_comb begin
        play       = state_q == PLAY;
        empty      = level_q == '0;
        full       = level_q == (AW+1)'(FIFO_DEPTH);
        head_len   = {1'b0, mem_q[rd_ptr_q][17:6]};
        head_color = mem_q[rd_ptr_q][5:0];
        push_req   = instr_valid && !valid_q;
        pop        = play && !empty && (display_on ? remain_q <= 13'd1 : remain_q == '0);
        push       = push_req && (!full || pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        level_d    = level_q + (AW+1)'(push) - (AW+1)'(pop);
        shift_d    = FIFO_DEPTH - int'(level_d) >= SHIFT_MARGIN;
        remain_d   = !play ? remain_q
                   : display_on ? (remain_q > 13'd1 ? remain_q - 13'd1
                                  : pop ? head_len + 13'(remain_q[0]) : 13'd0)
                   : pop ? head_len + 13'd1 : remain_q;
        rgb_d       = !(play && display_on) ? 6'd0 : remain_q != '0 ? cur_color_q : pop ? head_color : 6'd0;
        cur_color_d = pop ? head_color : cur_color_q;
        underrun_d  = underrun_q || (play && display_on && remain_q == '0 && empty);
        overflow_d  = overflow_q || (push_req && !push);
        state_d     = (!play && frame_start && !empty) ? PLAY : state_q;
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= instr;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SYNC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            remain_q    <= '0;
            cur_color_q <= '0;
            rgb_q       <= '0;
            shift_q     <= 1'b0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            remain_q    <= remain_d;
            cur_color_q <= cur_color_d;
            rgb_q       <= rgb_d;
            shift_q     <= shift_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
            valid_q     <= instr_valid;
        end
    end
    assign shift_data = shift_q;
    assign rgb        = rgb_q;
    assign playing    = state_q == PLAY;
    assign underrun   = underrun_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;
endmodule
